wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo2.sv | 78 +++++++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the write-back port arbiter: default
//               data/address widths and the rf_src source encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Encoding driven on rf_src for the granted channel
  localparam logic SRC_MEM = 1'b0;
  localparam logic SRC_ALU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry FIFO holding {addr, data} write-back requests.
//               Slot 0 is always the head, so the head outputs need no mux.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush           - synchronous empty
//               push/push_addr/push_data - enqueue (ignored when full)
//               pop             - dequeue head (ignored when empty)
//               count           - occupancy 0..2
//               head_addr/head_data - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo2
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] r_slot0;
  logic [ENT_W-1:0] r_slot1;
  logic [1:0]       r_count;
  logic [ENT_W-1:0] w_new;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_new     = {push_addr, push_data};
  assign w_push_ok = push && (r_count != 2'd2);
  assign w_pop_ok  = pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      unique case ({w_push_ok, w_pop_ok})
        2'b10: begin
          if (r_count == 2'd0) r_slot0 <= w_new;
          else                 r_slot1 <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Push+pop is only possible at occupancy 1 (not full, not empty):
          // the new entry directly replaces the departing head.
          r_slot0 <= w_new;
        end
        default: ;
      endcase
    end
  end

  assign count     = r_count;
  assign head_addr = r_slot0[ENT_W-1:DATA_W];
  assign head_data = r_slot0[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Merges memory-result and ALU-result streams into a single
//               register-file write port. Each channel is buffered in a
//               2-entry FIFO; memory has priority unless the ALU head has
//               waited STARVE_MAX grant cycles, in which case ALU is forced.
// Ports       : clk, rst, flush
//               mem_valid/mem_ready/mem_addr/mem_data - memory result channel
//               alu_valid/alu_ready/alu_addr/alu_data - ALU result channel
//               rf_we/rf_addr/rf_data/rf_src          - register-file write
//               busy                                  - any entry buffered
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_src,
  output logic              busy
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [1:0]          w_mem_count;
  logic [1:0]          w_alu_count;
  logic [ADDR_W-1:0]   w_mem_head_addr;
  logic [DATA_W-1:0]   w_mem_head_data;
  logic [ADDR_W-1:0]   w_alu_head_addr;
  logic [DATA_W-1:0]   w_alu_head_data;
  logic                w_mem_push;
  logic                w_alu_push;
  logic                w_mem_ne;
  logic                w_alu_ne;
  logic                w_grant_mem;
  logic                w_grant_alu;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rf_addr;
  logic [DATA_W-1:0]   r_rf_data;
  logic                r_rf_src;

  // Ready is held low during rst/flush so inputs offered then are dropped
  assign mem_ready  = (w_mem_count < 2'd2) && !rst && !flush;
  assign alu_ready  = (w_alu_count < 2'd2) && !rst && !flush;
  assign w_mem_push = mem_valid && mem_ready;
  assign w_alu_push = alu_valid && alu_ready;

  wb_fifo2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (w_mem_push),
    .push_addr (mem_addr),
    .push_data (mem_data),
    .pop       (w_grant_mem),
    .count     (w_mem_count),
    .head_addr (w_mem_head_addr),
    .head_data (w_mem_head_data)
  );

  wb_fifo2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (w_alu_push),
    .push_addr (alu_addr),
    .push_data (alu_data),
    .pop       (w_grant_alu),
    .count     (w_alu_count),
    .head_addr (w_alu_head_addr),
    .head_data (w_alu_head_data)
  );

  assign w_mem_ne = (w_mem_count != 2'd0);
  assign w_alu_ne = (w_alu_count != 2'd0);

  // Memory wins by default; a starved ALU head overrides it.
  assign w_grant_alu = w_alu_ne && (!w_mem_ne || (r_starve_cnt == STARVE_LIM));
  assign w_grant_mem = w_mem_ne && !w_grant_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_rf_we      <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_data    <= '0;
      r_rf_src     <= SRC_MEM;
    end else if (flush) begin
      r_starve_cnt <= '0;
      r_rf_we      <= 1'b0;
    end else begin
      r_rf_we <= w_grant_mem || w_grant_alu;
      if (w_grant_alu) begin
        r_rf_addr    <= w_alu_head_addr;
        r_rf_data    <= w_alu_head_data;
        r_rf_src     <= SRC_ALU;
        r_starve_cnt <= '0;
      end else if (w_grant_mem) begin
        r_rf_addr <= w_mem_head_addr;
        r_rf_data <= w_mem_head_data;
        r_rf_src  <= SRC_MEM;
        // The ALU head waited through this grant
        if (w_alu_ne && (r_starve_cnt != STARVE_LIM))
          r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end
    end
  end

  assign rf_we   = r_rf_we;
  assign rf_addr = r_rf_addr;
  assign rf_data = r_rf_data;
  assign rf_src  = r_rf_src;
  assign busy    = w_mem_ne || w_alu_ne;

endmodule
`default_nettype wire
